// File: rtl/pacman_clk_en.sv
// Reset stretcher and phase-accumulator clock-enable generator for the Pac-Man core.
// Latency: sys_resetn rises RST_CYCLES edges after resetn releases; first pix_en follows N accumulating edges later.
// No backpressure: free-running strobes; pause (PACMAN_PAUSE_EN build only) masks cpu_en one cycle late.
//
// Optional feature macro: PACMAN_PAUSE_EN (when undefined the pause input is ignored).

module pacman_clk_en #(
  parameter int unsigned ACC_W      = 16,
  parameter int unsigned PIX_INC    = 16384,
  parameter int unsigned RST_CYCLES = 1024
) (
  input  logic clk,
  input  logic resetn,
  input  logic pause,
  output logic sys_resetn,
  output logic pix_en,
  output logic cpu_en,
  output logic phase
);

  localparam int unsigned RCNT_W = $clog2(RST_CYCLES + 1);
  localparam logic [RCNT_W-1:0] RCNT_MAX = RCNT_W'(RST_CYCLES);
  localparam logic [ACC_W-1:0]  INC      = ACC_W'(PIX_INC);

  typedef enum logic {
    HOLD = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  logic [RCNT_W-1:0]  rcnt;
  logic [RCNT_W-1:0]  rcnt_nxt;
  logic               rcnt_done;
  logic [ACC_W-1:0]   acc;
  logic [ACC_W:0]     sum;
  logic               carry;
  logic               pause_gate;

  // Saturating next value of the reset-hold counter.
  always_comb begin
    rcnt_nxt = rcnt;
    if (rcnt != RCNT_MAX) begin
      rcnt_nxt = rcnt + 1'b1;
    end
  end

  assign rcnt_done = (rcnt_nxt == RCNT_MAX);

  // The carry out of the (ACC_W+1)-bit sum is the overflow that marks one pixel period.
  assign sum   = {1'b0, acc} + {1'b0, INC};
  assign carry = sum[ACC_W];

`ifdef PACMAN_PAUSE_EN
  // Pause request sampled once so cpu_en masking is glitch-free and one cycle late.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      pause_gate <= 1'b0;
    end else begin
      pause_gate <= pause;
    end
  end
`else
  logic unused_pause;
  assign unused_pause = pause;
  assign pause_gate   = 1'b0;
`endif

  // HOLD/RUN sequencer: reset stretch, then accumulate and emit registered strobes.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= HOLD;
      rcnt       <= '0;
      sys_resetn <= 1'b0;
      acc        <= '0;
      pix_en     <= 1'b0;
      cpu_en     <= 1'b0;
      phase      <= 1'b0;
    end else begin
      rcnt       <= rcnt_nxt;
      sys_resetn <= rcnt_done;
      case (state)
        HOLD: begin
          acc    <= '0;
          pix_en <= 1'b0;
          cpu_en <= 1'b0;
          phase  <= 1'b0;
          if (rcnt_done) begin
            state <= RUN;
          end
        end
        RUN: begin
          acc    <= sum[ACC_W-1:0];
          pix_en <= carry;
          // Only the second strobe of each pixel pair carries a CPU enable.
          cpu_en <= carry & phase & ~pause_gate;
          phase  <= phase ^ pix_en;
        end
        default: begin
          state <= HOLD;
        end
      endcase
    end
  end

endmodule
